// File: rtl/layer2_seq.sv
// rtl/layer2_seq.sv - layer-2 inference sequencer: clear, feed features, drain, argmax, done.
// Optional argmax scan compiled in with `define LAYER2_SEQ_ARGMAX_EN; otherwise class outputs are tied to 0.
module layer2_seq #(
    parameter int NUM_FEAT   = 64,
    parameter int NUM_NEURON = 10,
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [6:0]                   feat_rd_addr,
    input  logic [DATA_W-1:0]            feat_rd_data,
    output logic                         dp_clr,
    output logic [DATA_W-1:0]            dp_feature,
    output logic [6:0]                   dp_addr,
    input  logic [NUM_NEURON*ACC_W-1:0]  layer_out,
    output logic [3:0]                   class_idx,
    output logic [ACC_W-1:0]             class_score
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
`ifdef LAYER2_SEQ_ARGMAX_EN
        S_ARGMAX = 3'd5,
`endif
        S_DONE   = 3'd4
    } state_t;

    localparam logic [6:0] FEAT_LAST = 7'(NUM_FEAT - 1);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LAYER2_SEQ_ARGMAX_EN
    localparam logic [6:0] NEUR_LAST = 7'(NUM_NEURON - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                if (cnt_q == FEAT_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
`ifdef LAYER2_SEQ_ARGMAX_EN
            S_DRAIN: begin
                state_d = S_ARGMAX;
                cnt_d   = '0;
            end
            S_ARGMAX: begin
                if (cnt_q == NEUR_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
`else
            S_DRAIN: state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        dp_clr       = rst || (state_q == S_CLEAR);
        feat_rd_addr = '0;
        dp_feature   = '0;
        dp_addr      = '0;
        if (state_q == S_FEED) begin
            dp_addr      = cnt_q;
            dp_feature   = feat_rd_data;
            // Prefetch one ahead to hide the buffer's read latency.
            feat_rd_addr = (cnt_q == FEAT_LAST) ? FEAT_LAST : cnt_q + 7'd1;
        end
    end

`ifdef LAYER2_SEQ_ARGMAX_EN
    logic [3:0]               best_idx_q, class_idx_q, scan_idx;
    logic signed [ACC_W-1:0]  best_score_q, class_score_q, scan_score, cand;
    logic                     take;

    always_comb begin
        cand = '0;
        for (int j = 0; j < NUM_NEURON; j++) begin
            if (cnt_q == 7'(j)) cand = layer_out[j*ACC_W +: ACC_W];
        end
        // Strict compare keeps the lowest index on ties; neuron 0 seeds the scan.
        take       = (cnt_q == 7'd0) || (cand > best_score_q);
        scan_idx   = take ? cnt_q[3:0] : best_idx_q;
        scan_score = take ? cand : best_score_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx_q    <= '0;
            best_score_q  <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
        end else if (state_q == S_ARGMAX) begin
            best_idx_q   <= scan_idx;
            best_score_q <= scan_score;
            if (cnt_q == NEUR_LAST) begin
                class_idx_q   <= scan_idx;
                class_score_q <= scan_score;
            end
        end
    end

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
`else
    logic unused_layer_out;
    assign unused_layer_out = ^layer_out;
    assign class_idx        = '0;
    assign class_score      = '0;
`endif

endmodule

// File: tb/tb_layer2_seq.sv
// tb/tb_layer2_seq.sv - randomized and directed bench for layer2_seq with an argmax reference model.
module tb_layer2_seq;
    localparam int NF = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int AW = 48;
`ifdef LAYER2_SEQ_ARGMAX_EN
    localparam bit AM  = 1'b1;
    localparam int LAT = NF + NN + 3;
`else
    localparam bit AM  = 1'b0;
    localparam int LAT = NF + 3;
`endif
    localparam int PER = LAT + 1;

    logic              clk, rst, start, busy, done, dp_clr;
    logic [6:0]        feat_rd_addr, dp_addr;
    logic [DW-1:0]     feat_rd_data, dp_feature;
    logic [NN*AW-1:0]  layer_out;
    logic [3:0]        class_idx;
    logic [AW-1:0]     class_score;

    logic [DW-1:0]     mem [0:127];
    longint            lo  [NN];
    int                checks = 0;
    int                errors = 0;

    layer2_seq #(.NUM_FEAT(NF), .NUM_NEURON(NN), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data), .dp_clr(dp_clr),
        .dp_feature(dp_feature), .dp_addr(dp_addr), .layer_out(layer_out),
        .class_idx(class_idx), .class_score(class_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) feat_rd_data <= mem[feat_rd_addr];

    always_comb begin
        layer_out = '0;
        for (int k = 0; k < NN; k++) layer_out[k*AW +: AW] = lo[k][AW-1:0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_idx();
        int b = 0;
        if (!AM) return 0;
        for (int j = 1; j < NN; j++) if (lo[j] > lo[b]) b = j;
        return b;
    endfunction

    function automatic logic [AW-1:0] ref_score();
        longint v;
        if (!AM) return '0;
        v = lo[ref_idx()];
        return v[AW-1:0];
    endfunction

    task automatic chk_class(input string tag);
        chk({tag, "_idx"},   64'(class_idx),   64'(ref_idx()));
        chk({tag, "_score"}, 64'(class_score), 64'(ref_score()));
    endtask

    // One start pulse, then every cycle checked against the expected schedule.
    task automatic infer(input string tag);
        logic [DW-1:0] ef;
        int            k, ea;
        bit            feed;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            feed = (c >= 2) && (c <= NF + 1);
            k    = c - 2;
            ef   = feed ? mem[k] : '0;
            ea   = feed ? ((k + 1 > NF - 1) ? NF - 1 : k + 1) : 0;
            chk($sformatf("%s_clr@%0d", tag, c),  64'(dp_clr),       64'(c == 1));
            chk($sformatf("%s_addr@%0d", tag, c), 64'(dp_addr),      64'(feed ? k : 0));
            chk($sformatf("%s_feat@%0d", tag, c), 64'(dp_feature),   64'(ef));
            chk($sformatf("%s_rd@%0d", tag, c),   64'(feat_rd_addr), 64'(ea));
            chk($sformatf("%s_busy@%0d", tag, c), 64'(busy),         64'(c <= LAT));
            chk($sformatf("%s_done@%0d", tag, c), 64'(done),         64'(c == LAT));
            if (c >= LAT) chk_class($sformatf("%s@%0d", tag, c));
            @(negedge clk);
        end
    endtask

    initial begin
        int dcnt, c;
        int dcyc [3];
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        for (int j = 0; j < NN; j++) lo[j] = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_clr",  64'(dp_clr), 64'(1));
        chk("rst_rd",   64'(feat_rd_addr), 64'(0));
        chk("rst_feat", 64'(dp_feature), 64'(0));
        chk("rst_addr", 64'(dp_addr), 64'(0));
        chk("rst_idx",  64'(class_idx), 64'(0));
        chk("rst_score", 64'(class_score), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_clr", 64'(dp_clr), 64'(0));

        for (int i = 0; i < NF; i++) mem[i] = DW'(i + 1);
        lo[0] = 5;    lo[1] = -7;  lo[2] = 9;    infer("d_max");
        lo[0] = 9;    lo[1] = 9;   lo[2] = -1;   infer("d_tie");
        lo[0] = -100; lo[1] = -3;  lo[2] = -50;  infer("d_neg");

        // Reset in FEED k=2 must abort the run with no done and no result update.
        lo[0] = 1; lo[1] = 2; lo[2] = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_feed", 64'(dp_addr), 64'(2));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_clr",  64'(dp_clr), 64'(1));
        chk("abort_idx",  64'(class_idx), 64'(0));
        chk("abort_score", 64'(class_score), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet_done@%0d", i), 64'(done), 64'(0));
            chk($sformatf("abort_quiet_busy@%0d", i), 64'(busy), 64'(0));
        end
        infer("after_rst");

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NF; i++) mem[i] = DW'($urandom);
            for (int j = 0; j < NN; j++) begin
                if (it % 2 == 0) lo[j] = longint'($urandom_range(0, 6)) - 3;
                else             lo[j] = longint'(int'($urandom)) * 37;
            end
            infer($sformatf("rnd%0d", it));
        end

        // Held start: back-to-back runs at the maximum rate, requests during busy ignored.
        lo[0] = -4; lo[1] = 12; lo[2] = 12;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        dcnt = 0;
        c    = 1;
        while (dcnt < 3 && c < 100) begin
            if (done) begin
                dcyc[dcnt] = c;
                dcnt++;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk("b2b_count", 64'(dcnt), 64'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_done%0d", i), 64'(i < dcnt ? dcyc[i] : -1), 64'(LAT + i * PER));
        chk_class("b2b");

        repeat (PER) @(negedge clk);
        chk("final_idle", 64'(busy), 64'(0));
        chk_class("final_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/layer2_seq.md
LAYER2_SEQ -- requirements
Module: layer2_seq

Interface
REQ-001 Parameter NUM_FEAT, default 64: number of input features per inference (1..128, fits the 7-bit dp_addr).
REQ-002 Parameter NUM_NEURON, default 10: number of output neurons or classes (2..16).
REQ-003 Parameter DATA_W, default 16: signed feature width.
REQ-004 Parameter ACC_W, default 48: signed accumulator width per neuron.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request one inference; sampled only in IDLE.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 feat_rd_addr  output  7  feature-buffer read address; the buffer has 1-cycle read latency.
REQ-011 feat_rd_data  input  DATA_W  feature-buffer read data for the address issued in the previous cycle.
REQ-012 dp_clr  output  1  drives the datapath reset; the datapath loads bias when this is high.
REQ-013 dp_feature  output  DATA_W  feature to the datapath (signed).
REQ-014 dp_addr  output  7  weight column index to the datapath.
REQ-015 layer_out  input  NUM_NEURON*ACC_W  datapath accumulators; neuron k occupies bits [k*ACC_W +: ACC_W].
REQ-016 class_idx  output  4  argmax neuron index; held stable until the next done.
REQ-017 class_score  output  ACC_W  accumulator value of class_idx; held stable until the next done.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN, ARGMAX and DONE.
REQ-019 Transition IDLE->CLEAR when start=1; start during any other state SHALL be ignored, with no queuing.
REQ-020 CLEAR lasts 1 cycle: dp_clr=1, feat_rd_addr=0, dp_feature=0.
REQ-021 FEED lasts exactly NUM_FEAT cycles; in FEED cycle k: dp_addr=k, dp_feature=feat_rd_data, feat_rd_addr=k+1 (saturating at NUM_FEAT-1).
REQ-022 DRAIN lasts 1 cycle with dp_feature=0 so the last product lands in layer_out.
REQ-023 Outside FEED, dp_feature SHALL be 0 and dp_addr 0; this makes the free-running datapath accumulate nothing.
REQ-024 dp_clr SHALL be 1 in CLEAR and whenever rst=1, and 0 otherwise.
REQ-025 ARGMAX lasts NUM_NEURON cycles and scans j=0..NUM_NEURON-1 sequentially, with a signed ACC_W-bit compare.
REQ-026 ARGMAX SHALL take neuron 0 as the initial best.
REQ-027 In ARGMAX, a candidate replaces the best only if it is strictly greater, so the lowest index wins ties.
REQ-028 DONE lasts 1 cycle: done=1, class_idx and class_score updated from the scan result; next state IDLE.
REQ-029 Latency: done SHALL be high in the cycle NUM_FEAT+NUM_NEURON+3 cycles after the edge that sampled start (3 = CLEAR, DRAIN, DONE).
REQ-030 start asserted in the DONE cycle SHALL be ignored; start is honoured from IDLE on the next cycle.
REQ-031 The maximum throughput is one inference per NUM_FEAT+NUM_NEURON+4 cycles.

Reset
REQ-032 rst=1 SHALL force IDLE from any state, including mid-FEED or mid-ARGMAX; the partial result SHALL be discarded.
REQ-033 Reset values: busy=0, done=0, feat_rd_addr=0, dp_feature=0, dp_addr=0, class_idx=0, class_score=0, dp_clr=1 during reset.
REQ-034 The first start after reset release SHALL behave identically to the first start after power-up.

Configuration
REQ-035 The macro LAYER2_SEQ_ARGMAX_EN SHALL select whether the argmax logic is compiled in.
REQ-036 With LAYER2_SEQ_ARGMAX_EN defined: behaviour as REQ-025 to REQ-029.
REQ-037 Without LAYER2_SEQ_ARGMAX_EN: the ARGMAX state and comparator SHALL be absent, and DRAIN->DONE directly.
REQ-038 Without LAYER2_SEQ_ARGMAX_EN: done latency is NUM_FEAT+3 cycles, and class_idx=0 and class_score=0 permanently.

Verification
REQ-039 NUM_FEAT=4, NUM_NEURON=3, features {1,2,3,4}, start pulse -> dp_clr high 1 cycle, then dp_addr 0,1,2,3 with dp_feature 1,2,3,4 on consecutive cycles; done at cycle 10.
REQ-040 layer_out model {5,-7,9} -> class_idx=2, class_score=9; layer_out {9,9,-1} -> class_idx=0 (tie rule).
REQ-041 layer_out {-100,-3,-50} -> class_idx=1, class_score=-3 (signed compare).
REQ-042 rst pulse at FEED k=2 -> IDLE next cycle, busy=0, no done; a following start completes normally with the correct result.
REQ-043 start held high continuously -> back-to-back inferences, done pulses 11 cycles apart; start during busy ignored.
REQ-044 Build without LAYER2_SEQ_ARGMAX_EN, NUM_FEAT=4 -> done at cycle 7, class_idx=0.
